// File: rtl/f8_membus.sv
// F8 data-port front end for split even/odd byte RAM banks (16-bit big-endian or byte access).
// Define FAULT_DETECT_EN to enable the sticky out-of-range fault flag; otherwise fault is tied 0.
module f8_membus #(
  parameter int unsigned ADDRBITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        wide,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        fault,
  output logic [14:0] read_addr_even,
  output logic [14:0] read_addr_odd,
  input  logic [7:0]  read_data_even,
  input  logic [7:0]  read_data_odd,
  output logic [14:0] write_addr_even,
  output logic [14:0] write_addr_odd,
  output logic [7:0]  write_data_even,
  output logic [7:0]  write_data_odd,
  output logic        write_en_even,
  output logic        write_en_odd
);

  localparam int unsigned WIN_LO_INT = 32'h4000 - (32'd1 << ADDRBITS);
  localparam logic [15:0] WIN_LO     = 16'(WIN_LO_INT);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t      st, st_nx;
  logic        we_r, wide_r, odd_r, ok0_r, ok1_r;
  logic [15:0] addr_nx;
  logic        ok0_c, ok1_c;
  logic [7:0]  b0_wdata;
  logic [7:0]  d0, d1;

  function automatic logic in_win(input logic [15:0] a);
    return (a >= WIN_LO) && (a <= 16'h3fff);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nx;
  end

  // Writes also pass through CAPTURE so both access types ack three edges after req.
  always_comb begin
    st_nx = st;
    ack   = 1'b0;
    unique case (st)
      IDLE:    if (req) st_nx = ISSUE;
      ISSUE:   st_nx = CAPTURE;
      CAPTURE: st_nx = DONE;
      DONE: begin
        ack   = 1'b1;
        st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    addr_nx  = addr + 16'd1;
    ok0_c    = in_win(addr);
    ok1_c    = wide && in_win(addr_nx);
    b0_wdata = wide ? wdata[15:8] : wdata[7:0];
    d0       = ok0_r ? (odd_r ? read_data_odd  : read_data_even) : 8'hFF;
    d1       = ok1_r ? (odd_r ? read_data_even : read_data_odd)  : 8'hFF;
  end

  // Byte b0 lives in the bank selected by addr[0]; b1 (wide only) in the other bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r            <= 1'b0;
      wide_r          <= 1'b0;
      odd_r           <= 1'b0;
      ok0_r           <= 1'b0;
      ok1_r           <= 1'b0;
      rdata           <= '0;
      read_addr_even  <= '0;
      read_addr_odd   <= '0;
      write_addr_even <= '0;
      write_addr_odd  <= '0;
      write_data_even <= '0;
      write_data_odd  <= '0;
      write_en_even   <= 1'b0;
      write_en_odd    <= 1'b0;
    end else begin
      write_en_even <= 1'b0;
      write_en_odd  <= 1'b0;
      if (st == IDLE && req) begin
        we_r   <= we;
        wide_r <= wide;
        odd_r  <= addr[0];
        ok0_r  <= ok0_c;
        ok1_r  <= ok1_c;
        if (we) begin
          if (addr[0]) begin
            write_addr_odd <= addr[15:1];
            write_data_odd <= b0_wdata;
            write_en_odd   <= ok0_c;
            if (wide) begin
              write_addr_even <= addr_nx[15:1];
              write_data_even <= wdata[7:0];
              write_en_even   <= ok1_c;
            end
          end else begin
            write_addr_even <= addr[15:1];
            write_data_even <= b0_wdata;
            write_en_even   <= ok0_c;
            if (wide) begin
              write_addr_odd <= addr_nx[15:1];
              write_data_odd <= wdata[7:0];
              write_en_odd   <= ok1_c;
            end
          end
        end else begin
          if (addr[0]) begin
            read_addr_odd <= addr[15:1];
            if (wide) read_addr_even <= addr_nx[15:1];
          end else begin
            read_addr_even <= addr[15:1];
            if (wide) read_addr_odd <= addr_nx[15:1];
          end
        end
      end
      if (st == CAPTURE && !we_r)
        rdata <= wide_r ? {d0, d1} : {8'h00, d0};
    end
  end

`ifdef FAULT_DETECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault <= 1'b0;
    else if (st == CAPTURE && (!ok0_r || (wide_r && !ok1_r)))
      fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_f8_membus.sv
// Randomized self-checking bench for f8_membus against a byte-addressed memory model.
module tb_f8_membus;
  localparam int unsigned ADDRBITS = 10;
  localparam int unsigned WIN_LO   = 32'h4000 - (32'd1 << ADDRBITS);

  logic        clk = 1'b0;
  logic        reset, req, we, wide;
  logic [15:0] addr, wdata;
  logic        ack, fault;
  logic [15:0] rdata;
  logic [14:0] read_addr_even, read_addr_odd, write_addr_even, write_addr_odd;
  logic [7:0]  read_data_even, read_data_odd, write_data_even, write_data_odd;
  logic        write_en_even, write_en_odd;

  always #5 clk = ~clk;

  f8_membus #(.ADDRBITS(ADDRBITS)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .wide(wide), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .fault(fault),
    .read_addr_even(read_addr_even), .read_addr_odd(read_addr_odd),
    .read_data_even(read_data_even), .read_data_odd(read_data_odd),
    .write_addr_even(write_addr_even), .write_addr_odd(write_addr_odd),
    .write_data_even(write_data_even), .write_data_odd(write_data_odd),
    .write_en_even(write_en_even), .write_en_odd(write_en_odd)
  );

  // Bank RAMs with one-cycle registered read.
  logic [7:0]  bank_e [32768];
  logic [7:0]  bank_o [32768];
  logic        init_banks = 1'b0;
  int unsigned strobes_e = 0, strobes_o = 0;
  logic [14:0] last_wa_e = '0, last_wa_o = '0;

  // Behavioural reference: flat byte memory over the full 16-bit address space.
  logic [7:0]  ref_mem [65536];
  logic        exp_fault = 1'b0;
  int          n_checks = 0, n_fail = 0;

  function automatic logic [7:0] pattern(input int unsigned a);
    return 8'(a * 37 + 11 + (a >> 8));
  endfunction

  always @(posedge clk) begin
    if (init_banks) begin
      for (int i = 0; i < 32768; i++) begin
        bank_e[i] <= pattern(32'(2 * i));
        bank_o[i] <= pattern(32'(2 * i + 1));
      end
    end else begin
      if (write_en_even) begin
        bank_e[write_addr_even] <= write_data_even;
        strobes_e <= strobes_e + 1;
        last_wa_e <= write_addr_even;
      end
      if (write_en_odd) begin
        bank_o[write_addr_odd] <= write_data_odd;
        strobes_o <= strobes_o + 1;
        last_wa_o <= write_addr_odd;
      end
    end
    read_data_even <= bank_e[read_addr_even];
    read_data_odd  <= bank_o[read_addr_odd];
  end

  function automatic logic in_win(input logic [15:0] a);
    return (32'(a) >= WIN_LO) && (a <= 16'h3fff);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [15:0] a);
    return in_win(a) ? ref_mem[a] : 8'hFF;
  endfunction

  function automatic logic [15:0] exp_read(input logic [15:0] a, input logic w);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return w ? {ref_byte(a), ref_byte(a1)} : {8'h00, ref_byte(a)};
  endfunction

  // Applies an access to the model; returns expected per-bank strobe counts.
  task automatic model_access(input logic w_we, input logic w_wide, input logic [15:0] a,
                              input logic [15:0] d, output int ne, output int no);
    logic [15:0] bytes_a [2];
    logic [7:0]  bytes_d [2];
    int          nb;
    bytes_a[0] = a;
    bytes_a[1] = a + 16'd1;
    bytes_d[0] = w_wide ? d[15:8] : d[7:0];
    bytes_d[1] = d[7:0];
    nb = w_wide ? 2 : 1;
    ne = 0;
    no = 0;
    for (int k = 0; k < nb; k++) begin
      if (in_win(bytes_a[k])) begin
        if (w_we) begin
          ref_mem[bytes_a[k]] = bytes_d[k];
          if (bytes_a[k][0]) no++;
          else               ne++;
        end
      end else begin
`ifdef FAULT_DETECT_EN
        exp_fault = 1'b1;
`endif
      end
    end
  endtask

  // Drives one access and reports what the DUT did; returns with the DUT back in IDLE.
  task automatic do_access(input logic w_we, input logic w_wide, input logic [15:0] a,
                           input logic [15:0] d, output logic [15:0] rd, output int lat,
                           output logic flt, output int ne, output int no);
    int unsigned se0, so0;
    @(negedge clk);
    we = w_we; wide = w_wide; addr = a; wdata = d; req = 1'b1;
    se0 = strobes_e;
    so0 = strobes_o;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack === 1'b1) break;
    end
    rd  = rdata;
    flt = fault;
    req = 1'b0;
    @(posedge clk); #1;
    ne = int'(strobes_e - se0);
    no = int'(strobes_o - so0);
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; we = 1'b0; wide = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pattern(32'(i));
    init_banks = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
    n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
    n_checks++; if ({write_en_even, write_en_odd} !== 2'b00) begin n_fail++;
      $display("FAIL reset_wen got %b%b want 00", write_en_even, write_en_odd); end
    n_checks++; if ({read_addr_even, read_addr_odd, write_addr_even, write_addr_odd,
                     write_data_even, write_data_odd} !== 76'h0) begin n_fail++;
      $display("FAIL reset_bank_ports got %h %h %h %h %h %h want all 0", read_addr_even,
               read_addr_odd, write_addr_even, write_addr_odd, write_data_even, write_data_odd); end
    @(negedge clk);
    init_banks = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_byte;
    logic [15:0] rd; int lat, ne, no, xe, xo; logic flt;
    model_access(1'b1, 1'b0, 16'h3c01, 16'h00A5, xe, xo);
    do_access(1'b1, 1'b0, 16'h3c01, 16'h00A5, rd, lat, flt, ne, no);
    n_checks++; if (ne !== 0 || no !== 1) begin n_fail++;
      $display("FAIL byte_wr_strobes got e=%0d o=%0d want e=0 o=1", ne, no); end
    n_checks++; if (last_wa_o !== 15'h1e00) begin n_fail++;
      $display("FAIL byte_wr_addr got %h want 1e00", last_wa_o); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL byte_wr_latency got %0d want 3", lat); end
    model_access(1'b0, 1'b0, 16'h3c01, 16'h0, xe, xo);
    do_access(1'b0, 1'b0, 16'h3c01, 16'h0, rd, lat, flt, ne, no);
    n_checks++; if (rd !== 16'h00A5) begin n_fail++; $display("FAIL byte_rd_data got %h want 00a5", rd); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL byte_rd_latency got %0d want 3", lat); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_width got %b want 0", ack); end
  endtask

  task automatic test_wide(input logic [15:0] a, input logic [15:0] d,
                           input logic [14:0] ie, input logic [7:0] ve,
                           input logic [14:0] io, input logic [7:0] vo);
    logic [15:0] rd; int lat, ne, no, xe, xo; logic flt;
    model_access(1'b1, 1'b1, a, d, xe, xo);
    do_access(1'b1, 1'b1, a, d, rd, lat, flt, ne, no);
    n_checks++; if (ne !== 1 || no !== 1) begin n_fail++;
      $display("FAIL wide_wr_strobes %h got e=%0d o=%0d want 1 1", a, ne, no); end
    n_checks++; if (bank_e[ie] !== ve || bank_o[io] !== vo) begin n_fail++;
      $display("FAIL wide_wr_banks %h got %h %h want %h %h", a, bank_e[ie], bank_o[io], ve, vo); end
    do_access(1'b0, 1'b1, a, 16'h0, rd, lat, flt, ne, no);
    n_checks++; if (rd !== d) begin n_fail++; $display("FAIL wide_rd %h got %h want %h", a, rd, d); end
  endtask

  task automatic test_straddle;
    logic [15:0] rd; int lat, ne, no, xe, xo; logic flt;
    model_access(1'b1, 1'b0, 16'h3fff, 16'h007E, xe, xo);
    do_access(1'b1, 1'b0, 16'h3fff, 16'h007E, rd, lat, flt, ne, no);
    model_access(1'b0, 1'b1, 16'h3fff, 16'h0, xe, xo);
    do_access(1'b0, 1'b1, 16'h3fff, 16'h0, rd, lat, flt, ne, no);
    n_checks++; if (rd !== 16'h7EFF) begin n_fail++; $display("FAIL straddle_rd got %h want 7eff", rd); end
    n_checks++; if (flt !== exp_fault) begin n_fail++;
      $display("FAIL straddle_fault got %b want %b", flt, exp_fault); end
    model_access(1'b1, 1'b1, 16'h3bff, 16'h5AC3, xe, xo);
    do_access(1'b1, 1'b1, 16'h3bff, 16'h5AC3, rd, lat, flt, ne, no);
    n_checks++; if (ne !== 1 || no !== 0 || last_wa_e !== 15'h1e00) begin n_fail++;
      $display("FAIL straddle_wr got e=%0d o=%0d idx=%h want 1 0 1e00", ne, no, last_wa_e); end
    n_checks++; if (bank_e[15'h1e00] !== 8'hC3) begin n_fail++;
      $display("FAIL straddle_wr_data got %h want c3", bank_e[15'h1e00]); end
  endtask

  task automatic test_wrap;
    logic [15:0] rd; int lat, ne, no, xe, xo; logic flt;
    model_access(1'b0, 1'b1, 16'hffff, 16'h0, xe, xo);
    do_access(1'b0, 1'b1, 16'hffff, 16'h0, rd, lat, flt, ne, no);
    n_checks++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_rd got %h want ffff", rd); end
    n_checks++; if (read_addr_odd !== 15'h7fff || read_addr_even !== 15'h0) begin n_fail++;
      $display("FAIL wrap_rd_addr got o=%h e=%h want 7fff 0000", read_addr_odd, read_addr_even); end
    model_access(1'b1, 1'b1, 16'hffff, 16'h1111, xe, xo);
    do_access(1'b1, 1'b1, 16'hffff, 16'h1111, rd, lat, flt, ne, no);
    n_checks++; if (ne !== 0 || no !== 0) begin n_fail++;
      $display("FAIL wrap_wr_strobes got e=%0d o=%0d want 0 0", ne, no); end
    n_checks++; if (flt !== exp_fault) begin n_fail++; $display("FAIL wrap_fault got %b want %b", flt, exp_fault); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    we = 1'b0; wide = 1'b1; addr = 16'h3c10; wdata = '0; req = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; n++; if (ack === 1'b1) break; end
    n_checks++; if (n !== 3 || rdata !== exp_read(16'h3c10, 1'b1)) begin n_fail++;
      $display("FAIL b2b_first got lat=%0d %h want 3 %h", n, rdata, exp_read(16'h3c10, 1'b1)); end
    addr = 16'h3c11;
    n = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; n++; if (ack === 1'b1) break; end
    n_checks++; if (n !== 4 || rdata !== exp_read(16'h3c11, 1'b1)) begin n_fail++;
      $display("FAIL b2b_second got lat=%0d %h want 4 %h", n, rdata, exp_read(16'h3c11, 1'b1)); end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [15:0] rd, a, d, er; int lat, ne, no, xe, xo, bad; logic flt, w, wd;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(3))
        0:       a = 16'(32'h3bf8 + $urandom_range(23));
        1:       a = 16'(32'h3ff0 + $urandom_range(31));
        2:       a = 16'(32'hfffe + $urandom_range(3));
        default: a = 16'(WIN_LO + $urandom_range(1023));
      endcase
      w  = 1'($urandom_range(1));
      wd = 1'($urandom_range(1));
      d  = 16'($urandom);
      er = exp_read(a, wd);
      model_access(w, wd, a, d, xe, xo);
      do_access(w, wd, a, d, rd, lat, flt, ne, no);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rand_lat %h got %0d want 3", a, lat); end
      n_checks++; if (flt !== exp_fault) begin n_fail++; $display("FAIL rand_fault %h got %b want %b", a, flt, exp_fault); end
      if (w) begin
        n_checks++; if (ne !== xe || no !== xo) begin n_fail++;
          $display("FAIL rand_strobes %h got %0d %0d want %0d %0d", a, ne, no, xe, xo); end
      end else begin
        n_checks++; if (rd !== er || ne !== 0 || no !== 0) begin n_fail++;
          $display("FAIL rand_rd %h w=%b got %h want %h strobes %0d %0d", a, wd, rd, er, ne, no); end
      end
    end
  endtask

  task automatic test_reset_mid_write;
    logic [15:0] rd; int lat, ne, no, xe, xo, acks; logic flt;
    @(negedge clk);
    we = 1'b1; wide = 1'b1; addr = 16'h3c20; wdata = 16'hDEAD; req = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({write_en_even, write_en_odd} !== 2'b11) begin n_fail++;
      $display("FAIL midwr_issue_wen got %b%b want 11", write_en_even, write_en_odd); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if ({write_en_even, write_en_odd} !== 2'b00) begin n_fail++;
      $display("FAIL midwr_wen_drop got %b%b want 00", write_en_even, write_en_odd); end
    req = 1'b0;
    exp_fault = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (ack !== 1'b0) acks++; end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL midwr_spurious_ack got %0d want 0", acks); end
    n_checks++; if (fault !== 1'b0 || rdata !== 16'h0) begin n_fail++;
      $display("FAIL midwr_reset_state got fault=%b rdata=%h want 0 0000", fault, rdata); end
    model_access(1'b0, 1'b1, 16'h3c20, 16'h0, xe, xo);
    do_access(1'b0, 1'b1, 16'h3c20, 16'h0, rd, lat, flt, ne, no);
    n_checks++; if (rd !== exp_read(16'h3c20, 1'b1)) begin n_fail++;
      $display("FAIL midwr_mem got %h want %h", rd, exp_read(16'h3c20, 1'b1)); end
  endtask

  task automatic test_memory;
    int bad;
    bad = 0;
    for (int i = 0; i < 32768; i++) begin
      if (bank_e[i] !== ref_mem[2 * i])     bad++;
      if (bank_o[i] !== ref_mem[2 * i + 1]) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL memory_image got %0d bad bytes want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_byte;
    test_wide(16'h3c10, 16'h1234, 15'h1e08, 8'h12, 15'h1e08, 8'h34);
    test_wide(16'h3c11, 16'hBEEF, 15'h1e09, 8'hEF, 15'h1e08, 8'hBE);
    test_straddle;
    test_wrap;
    test_back_to_back;
    test_random;
    test_reset_mid_write;
    test_memory;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
